// File: rtl/sha256_core_arb_if.sv
// sha256_core_arb_if: requester, response and compression-core signals of the
// SHA-256 core arbiter. With SHA256_ARB_PERF_EN defined it also carries the
// perf_blocks / perf_stall counters.
interface sha256_core_arb_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]     req_valid;
    logic [NUM_REQ-1:0]     req_ready;
    logic [NUM_REQ*512-1:0] req_block;
    logic [NUM_REQ*256-1:0] req_h;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [ID_W-1:0]        rsp_id;
    logic [255:0]           rsp_digest;
    logic                   core_reset;
    logic [255:0]           core_h_in;
    logic [2047:0]          core_w;
    logic                   core_done;
    logic [255:0]           core_h_out;
`ifdef SHA256_ARB_PERF_EN
    logic [31:0]            perf_blocks;
    logic [31:0]            perf_stall;

    modport slave (
        input  req_valid, req_block, req_h, rsp_ready, core_done, core_h_out,
        output req_ready, rsp_valid, rsp_id, rsp_digest, core_reset, core_h_in, core_w,
        output perf_blocks, perf_stall
    );
    modport master (
        output req_valid, req_block, req_h, rsp_ready, core_done, core_h_out,
        input  req_ready, rsp_valid, rsp_id, rsp_digest, core_reset, core_h_in, core_w,
        input  perf_blocks, perf_stall
    );
`else
    modport slave (
        input  req_valid, req_block, req_h, rsp_ready, core_done, core_h_out,
        output req_ready, rsp_valid, rsp_id, rsp_digest, core_reset, core_h_in, core_w
    );
    modport master (
        output req_valid, req_block, req_h, rsp_ready, core_done, core_h_out,
        input  req_ready, rsp_valid, rsp_id, rsp_digest, core_reset, core_h_in, core_w
    );
`endif
endinterface

// File: rtl/sha256_core_arb.sv
// sha256_core_arb: round-robin scheduler sharing one SHA-256 compression core
// between NUM_REQ requesters. It latches a block and chaining value, expands
// the message schedule one word per cycle, runs the core, adds the
// feed-forward and returns the digest tagged with the requester id.
// Build option: define SHA256_ARB_PERF_EN to add the perf_blocks and
// perf_stall counters.
module sha256_core_arb #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic             clk,
    input  logic             reset,
    sha256_core_arb_if.slave bus
);

    typedef enum logic [2:0] {IDLE, EXPAND, RUN, CAPT, RESP} state_t;

    state_t            r_state;
    logic [ID_W-1:0]   r_rr_ptr;
    logic [ID_W-1:0]   r_id;
    logic [5:0]        r_idx;
    logic [31:0]       r_w [64];
    logic [31:0]       r_h [8];
    logic              r_rsp_valid;
    logic [255:0]      r_digest;

    logic [NUM_REQ-1:0] w_rot;
    logic               w_any;
    logic [ID_W-1:0]    w_off;
    logic [ID_W:0]      w_sum;
    logic [ID_W-1:0]    w_pick;
    logic               w_accept;
    logic [511:0]       w_blk;
    logic [255:0]       w_hsl;
    logic [5:0]         w_i2, w_i7, w_i15, w_i16;
    logic [31:0]        w_wnew;

    function automatic logic [31:0] f_ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] f_s0(input logic [31:0] x);
        return f_ror(x, 7) ^ f_ror(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] f_s1(input logic [31:0] x);
        return f_ror(x, 17) ^ f_ror(x, 19) ^ (x >> 10);
    endfunction

    // Rotate the request vector so bit 0 is the requester at rr_ptr; the lowest
    // set bit of the rotated vector is then the round-robin winner.
    assign w_rot = NUM_REQ'({bus.req_valid, bus.req_valid} >> r_rr_ptr);

    // Find the lowest set bit of the rotated request vector.
    always_comb begin
        w_any = 1'b0;
        w_off = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_any = 1'b1;
                w_off = ID_W'(k);
            end
        end
    end

    assign w_sum    = {1'b0, r_rr_ptr} + {1'b0, w_off};
    assign w_pick   = (w_sum >= (ID_W + 1)'(NUM_REQ)) ? ID_W'(w_sum - (ID_W + 1)'(NUM_REQ))
                                                       : w_sum[ID_W-1:0];
    assign w_accept = (r_state == IDLE) && w_any;

    // Grant is held low while reset is asserted so nothing is offered mid-reset.
    assign bus.req_ready = (w_accept && !reset) ? (NUM_REQ'(1) << w_pick) : '0;

    assign w_blk = bus.req_block[w_pick*512 +: 512];
    assign w_hsl = bus.req_h[w_pick*256 +: 256];

    // Message-schedule recurrence taps for the word being produced at r_idx.
    assign w_i2   = r_idx - 6'd2;
    assign w_i7   = r_idx - 6'd7;
    assign w_i15  = r_idx - 6'd15;
    assign w_i16  = r_idx - 6'd16;
    assign w_wnew = f_s1(r_w[w_i2]) + r_w[w_i7] + f_s0(r_w[w_i15]) + r_w[w_i16];

    // Core is held in reset everywhere except the run and capture window.
    assign bus.core_reset = !((r_state == RUN) || (r_state == CAPT));
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_id     = r_id;
    assign bus.rsp_digest = r_digest;

    for (genvar g = 0; g < 64; g++) begin : g_core_w
        assign bus.core_w[2047-32*g -: 32] = r_w[g];
    end

    for (genvar g = 0; g < 8; g++) begin : g_core_h
        assign bus.core_h_in[255-32*g -: 32] = r_h[g];
    end

    // Main scheduler FSM: accept, expand, run core, capture, respond.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_rr_ptr    <= '0;
            r_id        <= '0;
            r_idx       <= '0;
            r_rsp_valid <= 1'b0;
            r_digest    <= '0;
            for (int j = 0; j < 64; j++) r_w[j] <= '0;
            for (int j = 0; j < 8; j++)  r_h[j] <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        for (int j = 0; j < 16; j++) r_w[j] <= w_blk[511-32*j -: 32];
                        for (int j = 0; j < 8; j++)  r_h[j] <= w_hsl[255-32*j -: 32];
                        r_id     <= w_pick;
                        r_rr_ptr <= (w_pick == ID_W'(NUM_REQ - 1)) ? '0 : w_pick + 1'b1;
                        r_idx    <= 6'd16;
                        r_state  <= EXPAND;
                    end
                end
                EXPAND: begin
                    r_w[r_idx] <= w_wnew;
                    r_idx      <= r_idx + 6'd1;
                    if (r_idx == 6'd63) r_state <= RUN;
                end
                RUN: begin
                    if (bus.core_done) r_state <= CAPT;
                end
                CAPT: begin
                    for (int j = 0; j < 8; j++)
                        r_digest[255-32*j -: 32] <= r_h[j] + bus.core_h_out[255-32*j -: 32];
                    r_rsp_valid <= 1'b1;
                    r_state     <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef SHA256_ARB_PERF_EN
    logic [31:0] r_perf_blocks;
    logic [31:0] r_perf_stall;

    // Count delivered digests and response cycles lost to back-pressure.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf_blocks <= '0;
            r_perf_stall  <= '0;
        end else if (r_state == RESP) begin
            if (bus.rsp_ready) r_perf_blocks <= r_perf_blocks + 32'd1;
            else               r_perf_stall  <= r_perf_stall + 32'd1;
        end
    end

    assign bus.perf_blocks = r_perf_blocks;
    assign bus.perf_stall  = r_perf_stall;
`endif

endmodule

// File: tb/tb_sha256_core_arb.sv
// tb_sha256_core_arb: directed bench for sha256_core_arb with a behavioural
// SHA-256 compression core and hand-derived digest constants.
module tb_sha256_core_arb;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    localparam logic [255:0] H0        = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [511:0] BLK_ABC   = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};
    localparam logic [255:0] DIG_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] DIG_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    logic         clk        = 1'b0;
    logic         reset      = 1'b1;
    logic         stray_done = 1'b0;
    logic         m_done     = 1'b0;
    logic [255:0] m_hout     = '0;
    int           m_cnt      = 0;
    int           n_cmp      = 0;
    int           n_mis      = 0;

    always #5 clk = ~clk;

    sha256_core_arb_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

    sha256_core_arb #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    assign bus.core_done  = m_done | stray_done;
    assign bus.core_h_out = m_hout;

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // 64 SHA-256 rounds on the supplied schedule; returns working variables a..h.
    function automatic logic [255:0] compress(input logic [2047:0] w, input logic [255:0] hin);
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2, wi;
        {a, b, c, d, e, f, g, h} = hin;
        for (int i = 0; i < 64; i++) begin
            wi = w[2047-32*i -: 32];
            t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + wi;
            t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = d + t1;
            d = c; c = b; b = a; a = t1 + t2;
        end
        return {a, b, c, d, e, f, g, h};
    endfunction

    // Core model: done pulses 66 cycles after the first cycle out of reset.
    always @(posedge clk) begin
        if (bus.core_reset !== 1'b0) begin
            m_cnt  <= 0;
            m_done <= 1'b0;
        end else begin
            m_cnt  <= m_cnt + 1;
            m_done <= (m_cnt == 65);
            if (m_cnt == 65) m_hout <= compress(bus.core_w, bus.core_h_in);
        end
    end

    task automatic check_val(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Send one block from requester id and check latency, tag and digest;
    // stall > 0 holds rsp_ready low for that many response cycles.
    task automatic run_block(input int id, input logic [511:0] blk, input logic [255:0] hv,
                             input logic [255:0] exp_dig, input int stall);
        int lat;
        @(negedge clk);
        bus.req_block[id*512 +: 512] = blk;
        bus.req_h[id*256 +: 256]     = hv;
        bus.req_valid                = 4'b0001 << id;
        bus.rsp_ready                = (stall == 0);
        #1;
        check_val("grant", 256'(bus.req_ready), 256'(4'b0001 << id));
        @(posedge clk); #1;
        bus.req_valid = '0;
        check_val("ready_busy", 256'(bus.req_ready), 256'(0));
        lat = 1;
        while (bus.rsp_valid !== 1'b1 && lat < 300) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 10) check_val("core_rst_expand", 256'(bus.core_reset), 256'(1));
            if (lat == 60) check_val("core_rst_run", 256'(bus.core_reset), 256'(0));
        end
        check_val("latency", 256'(lat), 256'(117));
        check_val("rsp_id", 256'(bus.rsp_id), 256'(id));
        check_val("digest", bus.rsp_digest, exp_dig);
        if (stall > 0) begin
            bus.req_valid = 4'b0010;
            for (int i = 1; i < stall; i++) begin
                @(posedge clk); #1;
                check_val("stall_valid", 256'(bus.rsp_valid), 256'(1));
                check_val("stall_id", 256'(bus.rsp_id), 256'(id));
                check_val("stall_digest", bus.rsp_digest, exp_dig);
                check_val("stall_no_grant", 256'(bus.req_ready), 256'(0));
            end
            @(posedge clk); #1;
`ifdef SHA256_ARB_PERF_EN
            check_val("perf_stall", 256'(bus.perf_stall), 256'(stall));
`endif
            bus.rsp_ready = 1'b1;
            #1;
            check_val("resp_no_accept", 256'(bus.req_ready), 256'(0));
        end
        @(posedge clk); #1;
        check_val("rsp_drop", 256'(bus.rsp_valid), 256'(0));
        if (stall > 0) begin
            check_val("post_rsp_grant", 256'(bus.req_ready), 256'(4'b0010));
            bus.req_valid = '0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ng;
        int n_bad;
        int g_id [5];
        int g_cyc [5];
        int gi;

        bus.req_valid  = 4'b1111;
        bus.req_block  = '0;
        bus.req_h      = '0;
        bus.rsp_ready  = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state
        check_val("rst_req_ready", 256'(bus.req_ready), 256'(0));
        check_val("rst_rsp_valid", 256'(bus.rsp_valid), 256'(0));
        check_val("rst_rsp_id", 256'(bus.rsp_id), 256'(0));
        check_val("rst_digest", bus.rsp_digest, 256'(0));
        check_val("rst_core_reset", 256'(bus.core_reset), 256'(1));
        check_val("rst_core_w", 256'(|bus.core_w), 256'(0));
        check_val("rst_core_h", bus.core_h_in, 256'(0));
`ifdef SHA256_ARB_PERF_EN
        check_val("rst_perf_blocks", 256'(bus.perf_blocks), 256'(0));
        check_val("rst_perf_stall", 256'(bus.perf_stall), 256'(0));
`endif
        bus.req_valid = '0;
        @(negedge clk);
        reset = 1'b0;

        // Single blocks from different requesters
        run_block(0, BLK_ABC, H0, DIG_ABC, 0);
        run_block(2, BLK_EMPTY, H0, DIG_EMPTY, 0);

        // Stray core_done while idle
        @(negedge clk);
        stray_done = 1'b1;
        @(negedge clk);
        stray_done = 1'b0;
        repeat (3) @(negedge clk);
        check_val("stray_rsp_valid", 256'(bus.rsp_valid), 256'(0));
        check_val("stray_core_rst", 256'(bus.core_reset), 256'(1));
        run_block(1, BLK_ABC, H0, DIG_ABC, 0);

        // Back-pressure on the response
        do_reset();
        run_block(3, BLK_EMPTY, H0, DIG_EMPTY, 20);
`ifdef SHA256_ARB_PERF_EN
        check_val("perf_blocks", 256'(bus.perf_blocks), 256'(1));
        check_val("perf_stall_hold", 256'(bus.perf_stall), 256'(20));
`endif

        // Reset while the core is running
        do_reset();
        @(negedge clk);
        bus.req_block[511:0] = BLK_ABC;
        bus.req_h[255:0]     = H0;
        bus.req_valid        = 4'b0001;
        @(posedge clk); #1;
        bus.req_valid = '0;
        repeat (59) @(posedge clk);
        #1;
        check_val("mid_core_rst_run", 256'(bus.core_reset), 256'(0));
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_val("mid_rsp_valid", 256'(bus.rsp_valid), 256'(0));
        check_val("mid_core_rst", 256'(bus.core_reset), 256'(1));
        n_bad = 0;
        repeat (150) begin
            @(posedge clk); #1;
            if (bus.rsp_valid !== 1'b0) n_bad++;
        end
        check_val("mid_no_rsp", 256'(n_bad), 256'(0));
        run_block(0, BLK_ABC, H0, DIG_ABC, 0);

        // All requesters valid from reset: round-robin order and spacing
        @(negedge clk);
        reset = 1'b1;
        for (int r = 0; r < NUM_REQ; r++) begin
            bus.req_block[r*512 +: 512] = BLK_ABC;
            bus.req_h[r*256 +: 256]     = H0;
        end
        bus.req_valid = 4'b1111;
        bus.rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        ng = 0;
        for (int cyc = 0; cyc < 700 && ng < 5; cyc++) begin
            #1;
            if (bus.req_ready != '0) begin
                check_val("grant_onehot", 256'($onehot(bus.req_ready)), 256'(1));
                gi = -1;
                for (int b = 0; b < NUM_REQ; b++) if (bus.req_ready[b]) gi = b;
                g_id[ng]  = gi;
                g_cyc[ng] = cyc;
                ng++;
            end
            @(negedge clk);
        end
        bus.req_valid = '0;
        check_val("grant_count", 256'(ng), 256'(5));
        for (int k = 0; k < ng; k++) check_val("grant_order", 256'(g_id[k]), 256'(k % NUM_REQ));
        for (int k = 1; k < ng; k++) check_val("grant_spacing", 256'(g_cyc[k] - g_cyc[k-1]), 256'(118));
        do_reset();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
